// File: rtl/controller_pkg.sv
// controller_pkg: memory command encoding shared by the controller and its memory targets
package controller_pkg;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} memory_command_t;
endpackage

// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg: responder FSM states and latency limit
package memory_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESPOND = 2'd2} state_t;
  localparam int MAX_LATENCY = 15;
endpackage

// File: rtl/memory_array.sv
// memory_array: single-port DEPTHx32 RAM with byte write enables and registered read
module memory_array #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] index,
  input  logic          read_enable,
  input  logic [3:0]    write_enable,
  input  logic [31:0]   write_data,
  output logic [31:0]   read_data
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (write_enable[i]) mem[index][8*i +: 8] <= write_data[8*i +: 8];
  // Contents are never reset; only the output register is.
  always_ff @(posedge clk or posedge reset)
    if (reset) read_data <= '0;
    else if (read_enable) read_data <= mem[index];
endmodule

// File: rtl/memory_responder.sv
// memory_responder: single-outstanding memory target with fixed response latency
module memory_responder
  import memory_responder_pkg::*;
  import controller_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memory_enable,
  input  memory_command_t memory_command,
  input  logic [31:0]     address,
  input  logic [31:0]     write_data,
  input  logic [3:0]      write_mask,
  output logic            memory_ready,
  output logic            memory_valid,
  output logic [31:0]     read_data
);
  localparam int AW = $clog2(DEPTH);
  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("memory_responder: LATENCY out of range");
  end
  if ((1 << AW) != DEPTH) begin : g_bad_depth
    $error("memory_responder: DEPTH must be a power of two");
  end
  state_t          state, next_state;
  logic [3:0]      count;
  memory_command_t cmd_q, cmd_now;
  logic [AW-1:0]   idx_q, index;
  logic [31:0]     wdata_q;
  logic [3:0]      mask_q;
  logic            accept;
  assign accept = state == IDLE && memory_enable;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      cmd_q   <= READ;
      idx_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        count   <= 4'(LATENCY - 1);
        cmd_q   <= memory_command;
        idx_q   <= address[AW+1:2];
        wdata_q <= write_data;
        mask_q  <= write_mask;
      end else if (state == WAIT) count <= count - 4'd1;
    end
  always_comb begin
    next_state   = state == IDLE ? (memory_enable ? (LATENCY == 1 ? RESPOND : WAIT) : IDLE)
                 : state == WAIT ? (count == 4'd1 ? RESPOND : WAIT)
                 : IDLE;
    memory_ready = state == IDLE;
    memory_valid = state == RESPOND;
    cmd_now      = state == IDLE ? memory_command : cmd_q;
    index        = state == IDLE ? address[AW+1:2] : idx_q;
  end
  // Reads sample the array on the edge entering RESPOND; with LATENCY=1 that is the accept edge.
  memory_array #(.DEPTH(DEPTH)) u_array (
    .clk          (clk),
    .reset        (reset),
    .index        (index),
    .read_enable  (next_state == RESPOND && state != RESPOND && cmd_now == READ),
    .write_enable ({4{state == RESPOND && cmd_q == WRITE}} & mask_q),
    .write_data   (wdata_q),
    .read_data    (read_data)
  );
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: randomized checks of two responders (LATENCY 1 and 3) against a byte-level memory model
module tb_memory_responder;
  import controller_pkg::*;
  logic clk = 0, reset = 1;
  logic en [2];
  memory_command_t cmd [2];
  logic [31:0] addr [2], wd [2], rd [2];
  logic [3:0] wm [2];
  logic rdy [2], vld [2];
  logic [31:0] mdl [2][1024];
  logic [3:0] known [2][1024];
  logic [31:0] last_rd [2];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  memory_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .memory_enable(en[0]), .memory_command(cmd[0]), .address(addr[0]),
    .write_data(wd[0]), .write_mask(wm[0]), .memory_ready(rdy[0]), .memory_valid(vld[0]), .read_data(rd[0]));
  memory_responder #(.DEPTH(1024), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .memory_enable(en[1]), .memory_command(cmd[1]), .address(addr[1]),
    .write_data(wd[1]), .write_mask(wm[1]), .memory_ready(rdy[1]), .memory_valid(vld[1]), .read_data(rd[1]));

  task automatic txn(input int d, input memory_command_t c, input logic [31:0] a, input logic [31:0] data,
                     input logic [3:0] m, input bit hold, output logic [31:0] got);
    int lat = d ? 3 : 1;
    int idx = int'((a >> 2) % 1024);
    logic [31:0] km;
    checks++;
    if (rdy[d] !== 1'b1) begin errors++; $display("FAIL ready_before dut%0d got %b want 1", d, rdy[d]); end
    en[d] = 1; cmd[d] = c; addr[d] = a; wd[d] = data; wm[d] = m;
    @(posedge clk);
    got = 'x;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      en[d] = hold;
      cmd[d] = WRITE;
      addr[d] = 32'($urandom_range(0, 63));
      wd[d] = $urandom;
      wm[d] = 4'hF;
      checks++;
      if (rdy[d] !== 1'b0) begin errors++; $display("FAIL ready_busy dut%0d cyc%0d got %b want 0", d, n, rdy[d]); end
      checks++;
      if (vld[d] !== (n == lat)) begin errors++; $display("FAIL valid_timing dut%0d cyc%0d got %b want %b", d, n, vld[d], n == lat); end
      if (n == lat) begin
        got = rd[d];
        if (c == WRITE) begin
          checks++;
          if (rd[d] !== last_rd[d]) begin errors++; $display("FAIL rdata_hold dut%0d got %h want %h", d, rd[d], last_rd[d]); end
          for (int i = 0; i < 4; i++)
            if (m[i]) begin mdl[d][idx][8*i +: 8] = data[8*i +: 8]; known[d][idx][i] = 1; end
        end else begin
          for (int i = 0; i < 4; i++) km[8*i +: 8] = {8{known[d][idx][i]}};
          checks++;
          if ((rd[d] & km) !== (mdl[d][idx] & km))
            begin errors++; $display("FAIL read_data dut%0d idx%0d got %h want %h", d, idx, rd[d] & km, mdl[d][idx] & km); end
          last_rd[d] = rd[d];
        end
      end
    end
    @(negedge clk);
    checks++;
    if (rdy[d] !== 1'b1 || vld[d] !== 1'b0)
      begin errors++; $display("FAIL ready_return dut%0d got rdy=%b vld=%b want rdy=1 vld=0", d, rdy[d], vld[d]); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy[d] !== 1'b1 || vld[d] !== 1'b0 || rd[d] !== 32'h0)
        begin errors++; $display("FAIL reset_state dut%0d got rdy=%b vld=%b rd=%h want 1 0 0", d, rdy[d], vld[d], rd[d]); end
      last_rd[d] = 0;
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_latency1();
    logic [31:0] g;
    txn(0, READ, 32'h0, 0, 0, 0, g);
  endtask

  task automatic test_full_and_partial();
    logic [31:0] g;
    for (int d = 0; d < 2; d++) begin
      txn(d, WRITE, 32'h10, 32'hDEADBEEF, 4'b1111, 0, g);
      txn(d, READ, 32'h10, 0, 0, 0, g);
      checks++;
      if (g !== 32'hDEADBEEF) begin errors++; $display("FAIL full_write dut%0d got %h want deadbeef", d, g); end
      txn(d, WRITE, 32'h10, 32'h000000AA, 4'b0001, 0, g);
      txn(d, READ, 32'h10, 0, 0, 0, g);
      checks++;
      if (g !== 32'hDEADBEAA) begin errors++; $display("FAIL partial_write dut%0d got %h want deadbeaa", d, g); end
      txn(d, WRITE, 32'h10, 32'h12345678, 4'b0000, 0, g);
      txn(d, READ, 32'h10, 0, 0, 0, g);
      checks++;
      if (g !== 32'hDEADBEAA) begin errors++; $display("FAIL zero_mask dut%0d got %h want deadbeaa", d, g); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g;
    for (int k = 0; k < 12; k++)
      txn(1, k % 2 ? READ : WRITE, 32'($urandom_range(0, 15)) << 2, $urandom, 4'hF, 1, g);
    en[1] = 0;
  endtask

  task automatic test_abort();
    logic [31:0] g;
    txn(1, WRITE, 32'h20, 32'h11111111, 4'hF, 0, g);
    en[1] = 1; cmd[1] = WRITE; addr[1] = 32'h20; wd[1] = 32'h22222222; wm[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    en[1] = 0;
    checks++;
    if (rdy[1] !== 1'b0) begin errors++; $display("FAIL abort_wait got rdy=%b want 0", rdy[1]); end
    reset = 1;
    #1;
    checks++;
    if (rdy[1] !== 1'b1 || vld[1] !== 1'b0) begin errors++; $display("FAIL abort_reset got rdy=%b vld=%b want 1 0", rdy[1], vld[1]); end
    @(negedge clk);
    reset = 0;
    last_rd[0] = 0; last_rd[1] = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if (vld[1] !== 1'b0) begin errors++; $display("FAIL abort_novalid cyc%0d got %b want 0", n, vld[1]); end
    end
    txn(1, READ, 32'h20, 0, 0, 0, g);
    checks++;
    if (g !== 32'h11111111) begin errors++; $display("FAIL abort_commit got %h want 11111111", g); end
  endtask

  task automatic test_wrap();
    logic [31:0] g, v;
    for (int d = 0; d < 2; d++) begin
      v = $urandom;
      txn(d, WRITE, 32'h4, v, 4'hF, 0, g);
      txn(d, READ, 32'h1004, 0, 0, 0, g);
      checks++;
      if (g !== v) begin errors++; $display("FAIL wrap dut%0d got %h want %h", d, g, v); end
    end
  endtask

  task automatic test_random();
    logic [31:0] g, a;
    int d;
    for (int k = 0; k < 80; k++) begin
      d = $urandom_range(0, 1);
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      txn(d, $urandom_range(0, 1) ? WRITE : READ, a, $urandom, 4'($urandom), 1'($urandom), g);
      en[d] = 0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      en[d] = 0; cmd[d] = READ; addr[d] = 0; wd[d] = 0; wm[d] = 0; last_rd[d] = 0;
      for (int i = 0; i < 1024; i++) begin known[d][i] = 0; mdl[d][i] = 0; end
    end
    test_reset();
    test_latency1();
    test_full_and_partial();
    test_back_to_back();
    test_abort();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
